// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial sequence detector:
// default pattern, fill-counter type and the saturating increment helper.
package seq_det_pkg;

    localparam int DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

    typedef logic [$clog2(DEF_PAT_LEN)-1:0] fill_t;

    // Increment count, sticking at the largest value representable in width bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
        logic [31:0] max_v;
        if (width >= 32) begin
            max_v = 32'hFFFF_FFFF;
        end else begin
            max_v = (32'd1 << width) - 32'd1;
        end
        if (count >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = count + 32'd1;
        end
    endfunction

endpackage

// File: rtl/seq_det_history.sv
// History shift register of previously accepted bits plus a saturating
// fill counter telling how many of those bits are meaningful.
module seq_det_history
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clear,
    input  logic               in,
    output logic [PAT_LEN-2:0] hist,
    output logic               full
);

    localparam int FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;

    // Next history: clear wins over shift; the oldest bit falls off the top.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift) begin
            hist_d = (PAT_LEN - 1)'({hist_q, in});
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign full = (fill_q == FILL_MAX);

endmodule

// File: rtl/param_sequence_detector.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// input qualification, selectable overlap/output timing and a saturating match counter.
module param_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter int                 OVERLAP   = 1,
    parameter int                 MOORE     = 1,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(DEF_PATTERN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern_in,
    output logic               out,
    output logic [CNT_W-1:0]   match_count
);

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   match_count_q, match_count_d;

    logic [PAT_LEN-2:0] hist_s;
    logic               full_s;
    logic               accept_s;
    logic               match_now_s;
    logic               restart_s;

    seq_det_history #(
        .PAT_LEN (PAT_LEN)
    ) u_history (
        .clk   (clk),
        .reset (reset),
        .shift (accept_s),
        .clear (load | restart_s),
        .in    (in),
        .hist  (hist_s),
        .full  (full_s)
    );

    // A load cycle discards the presented bit, so it can never complete a match.
    always_comb begin
        accept_s    = in_valid & ~load;
        match_now_s = accept_s & full_s & ({hist_s, in} == pat_q);
        restart_s   = (OVERLAP == 0) ? match_now_s : 1'b0;
    end

    // Next pattern, Moore output and saturating counter.
    always_comb begin
        pat_d         = pat_q;
        out_d         = match_now_s;
        match_count_d = match_count_q;
        if (load) begin
            pat_d         = pattern_in;
            match_count_d = '0;
        end else if (match_now_s) begin
            match_count_d = CNT_W'(sat_inc(32'(match_count_q), CNT_W));
        end else begin
            match_count_d = match_count_q;
        end
    end

    // Pattern, output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q         <= PAT_RESET;
            out_q         <= 1'b0;
            match_count_q <= '0;
        end else begin
            pat_q         <= pat_d;
            out_q         <= out_d;
            match_count_q <= match_count_d;
        end
    end

    assign out         = (MOORE != 0) ? out_q : match_now_s;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Self-checking bench: four detector configurations driven from a vector table
// and hand-written sequences, with expectations queued and compared after each edge.
module tb_param_sequence_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       vld;
    logic       ld;
    logic [3:0] pat;
    logic       a_out, b_out, c_out, d_out;
    logic [7:0] a_cnt, b_cnt, c_cnt;
    logic [1:0] d_cnt;

    logic       d_rst;
    logic       d_in;
    logic       d_vld;
    logic       d_ld;
    logic [3:0] d_pat;

    always #5 clk = ~clk;

    param_sequence_detector u_a (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld), .load(ld),
        .pattern_in(pat), .out(a_out), .match_count(a_cnt)
    );

    param_sequence_detector #(.OVERLAP(0)) u_b (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld), .load(ld),
        .pattern_in(pat), .out(b_out), .match_count(b_cnt)
    );

    param_sequence_detector #(.MOORE(0)) u_c (
        .clk(clk), .reset(rst), .in(din), .in_valid(vld), .load(ld),
        .pattern_in(pat), .out(c_out), .match_count(c_cnt)
    );

    param_sequence_detector #(.CNT_W(2)) u_d (
        .clk(clk), .reset(d_rst), .in(d_in), .in_valid(d_vld), .load(d_ld),
        .pattern_in(d_pat), .out(d_out), .match_count(d_cnt)
    );

    typedef struct {
        logic       ld;
        logic       vld;
        logic       bit_in;
        logic [3:0] pat;
        logic       a_out;
        logic [7:0] a_cnt;
        logic       b_out;
        logic [7:0] b_cnt;
        logic       c_out;
        logic [7:0] c_cnt;
    } vec_t;

    typedef struct {
        logic       out;
        logic [1:0] cnt;
    } d_exp_t;

    vec_t   vecs[$];
    vec_t   exp_q[$];
    d_exp_t d_q[$];

    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(int l, int v, int b, int p, int ao, int ac, int bo, int bc, int co, int cc);
        vec_t r;
        r.ld = l[0];  r.vld = v[0];  r.bit_in = b[0];  r.pat = p[3:0];
        r.a_out = ao[0]; r.a_cnt = ac[7:0];
        r.b_out = bo[0]; r.b_cnt = bc[7:0];
        r.c_out = co[0]; r.c_cnt = cc[7:0];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic d_step(input logic r, input logic v, input logic b, input int eo, input int ec, input string name);
        d_exp_t e;
        d_exp_t got;
        d_rst = r; d_vld = v; d_in = b;
        e.out = eo[0]; e.cnt = ec[1:0];
        d_q.push_back(e);
        @(posedge clk); #1;
        got = d_q.pop_front();
        check({name, " d_out"}, int'(d_out), int'(got.out));
        check({name, " d_cnt"}, int'(d_cnt), int'(got.cnt));
    endtask

    initial begin
        vec_t   cur;
        vec_t   e;
        logic   c_comb;
        logic [3:0] dp;
        int     m;

        rst = 1'b1; din = 1'b0; vld = 1'b0; ld = 1'b0; pat = 4'h0;
        d_rst = 1'b1; d_in = 1'b0; d_vld = 1'b0; d_ld = 1'b0; d_pat = 4'h0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; d_rst = 1'b0;

        check("reset a_out", int'(a_out), 0);
        check("reset a_cnt", int'(a_cnt), 0);
        check("reset b_out", int'(b_out), 0);
        check("reset c_out", int'(c_out), 0);
        check("reset c_cnt", int'(c_cnt), 0);
        check("reset d_cnt", int'(d_cnt), 0);

        //                  ld vld bit pat  ao ac  bo bc  co cc
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  1, 1,  1, 1,  1, 1));
        vecs.push_back(mk(0, 1, 0, 0,  0, 1,  0, 1,  0, 1));
        vecs.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  0, 1));
        vecs.push_back(mk(0, 1, 1, 0,  1, 2,  0, 1,  1, 2));
        vecs.push_back(mk(0, 1, 1, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 1, 0, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 1, 1, 0,  0, 2,  0, 1,  0, 2));
        vecs.push_back(mk(0, 1, 1, 0,  1, 3,  1, 2,  1, 3));
        vecs.push_back(mk(0, 0, 0, 0,  0, 3,  0, 2,  0, 3));
        vecs.push_back(mk(0, 1, 1, 0,  0, 3,  0, 2,  0, 3));
        vecs.push_back(mk(0, 1, 0, 0,  0, 3,  0, 2,  0, 3));
        vecs.push_back(mk(0, 1, 1, 0,  0, 3,  0, 2,  0, 3));
        vecs.push_back(mk(1, 1, 1, 6,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 0,  0, 0,  0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 0, 0,  1, 1,  1, 1,  1, 1));
        vecs.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  0, 1));
        vecs.push_back(mk(0, 1, 1, 0,  0, 1,  0, 1,  0, 1));
        vecs.push_back(mk(0, 1, 0, 0,  1, 2,  0, 1,  1, 2));
        vecs.push_back(mk(0, 0, 0, 0,  0, 2,  0, 1,  0, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            cur = vecs[i];
            ld = cur.ld; vld = cur.vld; din = cur.bit_in; pat = cur.pat;
            exp_q.push_back(cur);
            #2;
            c_comb = c_out;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            check($sformatf("vec%0d a_out", i), int'(a_out), int'(e.a_out));
            check($sformatf("vec%0d a_cnt", i), int'(a_cnt), int'(e.a_cnt));
            check($sformatf("vec%0d b_out", i), int'(b_out), int'(e.b_out));
            check($sformatf("vec%0d b_cnt", i), int'(b_cnt), int'(e.b_cnt));
            check($sformatf("vec%0d c_comb", i), int'(c_comb), int'(e.c_out));
            check($sformatf("vec%0d c_cnt", i), int'(c_cnt), int'(e.c_cnt));
        end
        ld = 1'b0; vld = 1'b0; din = 1'b0;

        // Saturation: five back-to-back 1011 patterns on the 2-bit counter.
        dp = 4'b1011;
        m = 0;
        for (int i = 0; i < 20; i++) begin
            if ((i % 4) == 3) m++;
            d_step(1'b0, 1'b1, dp[3 - (i % 4)], ((i % 4) == 3) ? 1 : 0, (m > 3) ? 3 : m,
                   $sformatf("sat%0d", i));
        end

        // Partial 101, then reset in the cycle that would have completed it.
        d_step(1'b0, 1'b1, 1'b1, 0, 3, "part1");
        d_step(1'b0, 1'b1, 1'b0, 0, 3, "part0");
        d_step(1'b0, 1'b1, 1'b1, 0, 3, "part1b");
        d_step(1'b1, 1'b1, 1'b1, 0, 0, "rst_mid");
        d_step(1'b0, 1'b1, 1'b1, 0, 0, "post_rst1");
        d_step(1'b0, 1'b1, 1'b0, 0, 0, "post_rst2");
        d_step(1'b0, 1'b1, 1'b1, 0, 0, "post_rst3");
        d_step(1'b0, 1'b1, 1'b1, 1, 1, "post_rst4");
        d_step(1'b0, 1'b0, 1'b0, 0, 1, "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
